// File: rtl/mem_bus_arbiter_if.sv
// SRAM-like bus port: request fields flow master -> slave, handshakes and read data flow back.
interface mem_bus_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between fetch (inst) and load/store (data) ports, fixed priority
// data over inst, with an in-order ID FIFO routing responses back to the issuing port.
module mem_bus_arbiter #(
  parameter int unsigned OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_arbiter_if.slave  inst,
  mem_bus_arbiter_if.slave  data,
  mem_bus_arbiter_if.master mem,
  output logic              err_unexp
);

  localparam int unsigned PtrW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(OUTSTANDING + 1);

  logic                   lock_q, lock_d;
  logic                   owner_q, owner_d;
  logic [OUTSTANDING-1:0] id_q;
  logic [PtrW-1:0]        wptr_q, wptr_d;
  logic [PtrW-1:0]        rptr_q, rptr_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic gnt_valid, gnt_data;
  logic gnt_req, not_full;
  logic hs, pop, head_id;

  // A stalled request keeps its grant so the bus fields cannot change before acceptance.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_data  = 1'b0;
    if (lock_q) begin
      gnt_valid = 1'b1;
      gnt_data  = owner_q;
    end else if (data.req) begin
      gnt_valid = 1'b1;
      gnt_data  = 1'b1;
    end else if (inst.req) begin
      gnt_valid = 1'b1;
      gnt_data  = 1'b0;
    end
  end

  // Full check on registered count only: a same-cycle response never unblocks a request.
  assign not_full = (cnt_q < CntW'(OUTSTANDING));
  assign gnt_req  = gnt_data ? data.req : inst.req;

  always_comb begin
    mem.req   = 1'b0;
    mem.wr    = 1'b0;
    mem.size  = 2'd0;
    mem.wstrb = 4'd0;
    mem.addr  = 32'd0;
    mem.wdata = 32'd0;
    if (gnt_valid) begin
      mem.req = gnt_req & not_full;
      if (gnt_data) begin
        mem.wr    = data.wr;
        mem.size  = data.size;
        mem.wstrb = data.wstrb;
        mem.addr  = data.addr;
        mem.wdata = data.wdata;
      end else begin
        mem.wr    = inst.wr;
        mem.size  = inst.size;
        mem.wstrb = inst.wstrb;
        mem.addr  = inst.addr;
        mem.wdata = inst.wdata;
      end
    end
  end

  assign hs           = mem.req & mem.addr_ok;
  assign inst.addr_ok = hs & ~gnt_data;
  assign data.addr_ok = hs & gnt_data;

  assign pop          = mem.data_ok & (cnt_q != '0);
  assign head_id      = id_q[rptr_q];
  assign inst.data_ok = pop & ~head_id;
  assign data.data_ok = pop & head_id;
  assign inst.rdata   = mem.rdata;
  assign data.rdata   = mem.rdata;

  assign err_unexp = err_q;

  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    if (mem.req && !mem.addr_ok) begin
      lock_d  = 1'b1;
      owner_d = gnt_data;
    end else if (hs) begin
      lock_d = 1'b0;
    end

    if (hs) begin
      wptr_d = (wptr_q == PtrW'(OUTSTANDING - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = (rptr_q == PtrW'(OUTSTANDING - 1)) ? '0 : rptr_q + 1'b1;
    end
    cnt_d = cnt_q + CntW'(hs) - CntW'(pop);

    if (mem.data_ok && (cnt_q == '0)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q  <= 1'b0;
      owner_q <= 1'b0;
      id_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (hs) begin
        id_q[wptr_q] <= gnt_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: arbitration, lock, full stall, in-order routing, errors, reset.
module tb_mem_bus_arbiter;

  logic clk;
  logic reset;
  logic err_unexp;

  int unsigned n_cmp;
  int unsigned n_err;

  mem_bus_arbiter_if inst_if ();
  mem_bus_arbiter_if data_if ();
  mem_bus_arbiter_if mem_if ();

  mem_bus_arbiter #(
    .OUTSTANDING (2)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .inst      (inst_if.slave),
    .data      (data_if.slave),
    .mem       (mem_if.master),
    .err_unexp (err_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow after settling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_if.req   = 1'b0;
    inst_if.wr    = 1'b0;
    inst_if.size  = 2'd0;
    inst_if.wstrb = 4'h0;
    inst_if.addr  = 32'h0;
    inst_if.wdata = 32'h0;
    data_if.req   = 1'b0;
    data_if.wr    = 1'b0;
    data_if.size  = 2'd0;
    data_if.wstrb = 4'h0;
    data_if.addr  = 32'h0;
    data_if.wdata = 32'h0;
    mem_if.addr_ok = 1'b0;
    mem_if.data_ok = 1'b0;
    mem_if.rdata   = 32'h0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    idle();
    tick();
    tick();
    #2;
    check_eq("rst_mem_req", {31'd0, mem_if.req}, 32'd0);
    check_eq("rst_inst_addr_ok", {31'd0, inst_if.addr_ok}, 32'd0);
    check_eq("rst_data_addr_ok", {31'd0, data_if.addr_ok}, 32'd0);
    check_eq("rst_data_oks", {30'd0, inst_if.data_ok, data_if.data_ok}, 32'd0);
    check_eq("rst_err", {31'd0, err_unexp}, 32'd0);
    tick();
    reset = 1'b0;
    #2;
    check_eq("post_rst_mem_req", {31'd0, mem_if.req}, 32'd0);

    // Both ports request together: data wins.
    tick();
    inst_if.req = 1'b1; inst_if.addr = 32'h100; inst_if.wstrb = 4'hC;
    data_if.req = 1'b1; data_if.addr = 32'h200; data_if.wr = 1'b1;
    data_if.wstrb = 4'h3; data_if.size = 2'd1; data_if.wdata = 32'hDEAD_BEEF;
    mem_if.addr_ok = 1'b1;
    #2;
    check_eq("both_mem_req", {31'd0, mem_if.req}, 32'd1);
    check_eq("both_mem_addr", mem_if.addr, 32'h200);
    check_eq("both_mem_wr", {31'd0, mem_if.wr}, 32'd1);
    check_eq("both_mem_wstrb", {28'd0, mem_if.wstrb}, 32'h3);
    check_eq("both_mem_wdata", mem_if.wdata, 32'hDEAD_BEEF);
    check_eq("both_data_addr_ok", {31'd0, data_if.addr_ok}, 32'd1);
    check_eq("both_inst_addr_ok", {31'd0, inst_if.addr_ok}, 32'd0);
    tick();
    idle();
    mem_if.data_ok = 1'b1; mem_if.rdata = 32'hAAAA_5555;
    #2;
    check_eq("rsp1_data_data_ok", {31'd0, data_if.data_ok}, 32'd1);
    check_eq("rsp1_inst_data_ok", {31'd0, inst_if.data_ok}, 32'd0);
    check_eq("rsp1_data_rdata", data_if.rdata, 32'hAAAA_5555);
    check_eq("rsp1_mem_req_idle", {31'd0, mem_if.req}, 32'd0);

    // Inst stalled three cycles; data arriving meanwhile must not steal the bus.
    tick();
    idle();
    inst_if.req = 1'b1; inst_if.addr = 32'h300;
    #2;
    check_eq("lock_c1_addr", mem_if.addr, 32'h300);
    check_eq("lock_c1_inst_addr_ok", {31'd0, inst_if.addr_ok}, 32'd0);
    tick();
    data_if.req = 1'b1; data_if.addr = 32'h400;
    #2;
    check_eq("lock_c2_addr", mem_if.addr, 32'h300);
    check_eq("lock_c2_data_addr_ok", {31'd0, data_if.addr_ok}, 32'd0);
    tick();
    #2;
    check_eq("lock_c3_addr", mem_if.addr, 32'h300);
    tick();
    mem_if.addr_ok = 1'b1;
    #2;
    check_eq("lock_c4_addr", mem_if.addr, 32'h300);
    check_eq("lock_c4_inst_addr_ok", {31'd0, inst_if.addr_ok}, 32'd1);
    check_eq("lock_c4_data_addr_ok", {31'd0, data_if.addr_ok}, 32'd0);
    tick();
    inst_if.req = 1'b0;
    #2;
    check_eq("lock_c5_addr", mem_if.addr, 32'h400);
    check_eq("lock_c5_data_addr_ok", {31'd0, data_if.addr_ok}, 32'd1);

    // Two outstanding (inst, data): a third request is held off.
    tick();
    data_if.req = 1'b0;
    inst_if.req = 1'b1; inst_if.addr = 32'h500;
    #2;
    check_eq("full_mem_req", {31'd0, mem_if.req}, 32'd0);
    check_eq("full_inst_addr_ok", {31'd0, inst_if.addr_ok}, 32'd0);
    tick();
    mem_if.data_ok = 1'b1; mem_if.rdata = 32'h1111_1111;
    #2;
    check_eq("pop1_mem_req_same_cycle", {31'd0, mem_if.req}, 32'd0);
    check_eq("pop1_inst_data_ok", {31'd0, inst_if.data_ok}, 32'd1);
    check_eq("pop1_data_data_ok", {31'd0, data_if.data_ok}, 32'd0);
    check_eq("pop1_inst_rdata", inst_if.rdata, 32'h1111_1111);
    tick();
    mem_if.rdata = 32'h2222_2222;
    #2;
    check_eq("pop2_mem_req", {31'd0, mem_if.req}, 32'd1);
    check_eq("pop2_inst_addr_ok", {31'd0, inst_if.addr_ok}, 32'd1);
    check_eq("pop2_data_data_ok", {31'd0, data_if.data_ok}, 32'd1);
    check_eq("pop2_inst_data_ok", {31'd0, inst_if.data_ok}, 32'd0);
    check_eq("pop2_data_rdata", data_if.rdata, 32'h2222_2222);

    // Leave one inst outstanding and data locked, then reset mid-transaction.
    tick();
    idle();
    data_if.req = 1'b1; data_if.addr = 32'h600;
    #2;
    check_eq("prerst_addr", mem_if.addr, 32'h600);
    check_eq("prerst_err", {31'd0, err_unexp}, 32'd0);
    tick();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    inst_if.req = 1'b1; inst_if.addr = 32'h700;
    mem_if.data_ok = 1'b1; mem_if.rdata = 32'h3333_3333;
    #2;
    check_eq("rst_mid_addr", mem_if.addr, 32'h700);
    check_eq("rst_mid_mem_req", {31'd0, mem_if.req}, 32'd1);
    check_eq("rst_mid_data_oks", {30'd0, inst_if.data_ok, data_if.data_ok}, 32'd0);
    check_eq("rst_mid_err_not_yet", {31'd0, err_unexp}, 32'd0);
    tick();
    mem_if.data_ok = 1'b0;
    mem_if.addr_ok = 1'b1;
    #2;
    check_eq("err_set", {31'd0, err_unexp}, 32'd1);
    check_eq("rst_mid_inst_addr_ok", {31'd0, inst_if.addr_ok}, 32'd1);
    tick();
    idle();
    mem_if.data_ok = 1'b1; mem_if.rdata = 32'h4444_4444;
    #2;
    check_eq("late_inst_data_ok", {31'd0, inst_if.data_ok}, 32'd1);
    check_eq("late_inst_rdata", inst_if.rdata, 32'h4444_4444);
    tick();
    mem_if.data_ok = 1'b0;
    tick();
    #2;
    check_eq("err_held", {31'd0, err_unexp}, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    check_eq("err_cleared", {31'd0, err_unexp}, 32'd0);
    check_eq("final_mem_req", {31'd0, mem_if.req}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter OUTSTANDING, default 2, max accepted-but-unanswered bus transactions (1..4).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 inst_req  input  1  fetch-side request valid.
REQ-005 inst_wr / inst_size / inst_wstrb / inst_addr / inst_wdata  input  1/2/4/32/32  fetch-side request fields.
REQ-006 inst_addr_ok  output  1  fetch request accepted this cycle.
REQ-007 inst_data_ok  output  1  fetch response returned this cycle.
REQ-008 inst_rdata  output  32  fetch response data.
REQ-009 data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  input  1/1/2/4/32/32  load/store-side request, same meaning.
REQ-010 data_addr_ok, data_data_ok  output  1/1; data_rdata  output  32  load/store-side handshake and data.
REQ-011 mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  output  1/1/2/4/32/32  shared SRAM-like bus request.
REQ-012 mem_addr_ok, mem_data_ok  input  1/1; mem_rdata  input  32  shared bus handshake and data.
REQ-013 err_unexp  output  1  sticky flag: mem_data_ok seen with no outstanding transaction.

Function
REQ-014 Block SHALL share one SRAM-like bus between fetch and load/store ports; request path combinational (zero-cycle), bookkeeping registered.
REQ-015 State: lock (1 bit), owner (1 bit, 0=inst, 1=data), ID FIFO of OUTSTANDING entries, count (0..OUTSTANDING), err_unexp.
REQ-016 Arbitration when lock=0: data port wins if data_req=1, else inst port if inst_req=1; fixed priority, data over inst.
REQ-017 When lock=1, grant SHALL be owner regardless of other port's req.
REQ-018 mem_req = granted port's req AND count<OUTSTANDING; mem_wr/size/wstrb/addr/wdata muxed from granted port; when nothing granted, fields driven 0.
REQ-019 Full check uses registered count only; a same-cycle pop SHALL NOT unblock a request (no comb path mem_data_ok -> mem_req).
REQ-020 Address handshake = mem_req & mem_addr_ok; winner's *_addr_ok = handshake, loser's *_addr_ok = 0.
REQ-021 If mem_req=1 and mem_addr_ok=0: next lock=1, owner=granted port (bus fields SHALL stay sourced from that port until handshake); on handshake lock clears next cycle.
REQ-022 Each address handshake SHALL push winner ID into FIFO tail; count+1.
REQ-023 Responses in order: on mem_data_ok with count>0, head ID selects inst_data_ok or data_data_ok (exactly one, same cycle); pop head; count-1.
REQ-024 inst_rdata and data_rdata SHALL both equal mem_rdata combinationally; only data_ok qualifies.
REQ-025 Push and pop in same cycle: count unchanged, FIFO pointers both advance, both wrap modulo OUTSTANDING.
REQ-026 Same-cycle push of a request and pop of its own ID impossible; response for a handshake arrives earliest next cycle.
REQ-027 mem_data_ok with count=0: no *_data_ok asserted, count stays 0, err_unexp set to 1 and held until reset.
REQ-028 Requester deasserting req while locked is a protocol violation; block keeps lock, bench SHALL not generate it.

Reset
REQ-029 While reset=1 at posedge: count=0, FIFO pointers=0, lock=0, owner=0, err_unexp=0.
REQ-030 During and after reset (before any request): mem_req=0, all *_addr_ok=0, all *_data_ok=0.
REQ-031 Reset mid-transaction SHALL discard outstanding IDs; subsequent mem_data_ok for pre-reset transactions sets err_unexp.

Verification
REQ-032 Both ports request same cycle, mem_addr_ok=1 -> mem_addr=data_addr, data_addr_ok=1, inst_addr_ok=0; next mem_data_ok -> data_data_ok=1 only.
REQ-033 inst_req alone, mem_addr_ok low 3 cycles, data_req rises cycle 2 -> mem_addr stays inst_addr through lock; inst_addr_ok on cycle 4; data granted cycle 5.
REQ-034 OUTSTANDING=2, handshakes inst then data, no responses -> third request sees mem_req=0; pop with mem_data_ok -> mem_req=1 next cycle, not same cycle.
REQ-035 Two outstanding (inst, data), two mem_data_ok with rdata 0x11111111 then 0x22222222 -> inst_data_ok with 0x11111111, then data_data_ok with 0x22222222.
REQ-036 mem_data_ok with count=0 -> no data_ok, err_unexp=1 held; reset=1 one cycle -> err_unexp=0.
REQ-037 Reset asserted with count=1 -> count=0, lock=0 next cycle; following mem_data_ok sets err_unexp.
